// File: rtl/cdr_lock_sequencer.sv
// cdr_lock_sequencer: acquisition/lock controller for the baud-rate
// Mueller-Muller CDR loop. It steps the PI loop filter through
// clear -> fast acquisition -> slow tracking -> locked, and qualifies lock
// from windowed counts of small phase-detector errors.
module cdr_lock_sequencer #(
    parameter int DATA_W       = 16,
    parameter int WIN_LEN      = 256,
    parameter int GOOD_MIN     = 240,
    parameter int ERR_THR      = 64,
    parameter int CLR_CYCLES   = 8,
    parameter int KP_ACQ       = 8,
    parameter int KI_ACQ       = 14,
    parameter int KP_TRK       = 12,
    parameter int KI_TRK       = 18,
    parameter int ACQ_WINDOWS  = 4,
    parameter int LOCK_WINDOWS = 8,
    parameter int FAIL_WINDOWS = 2,
    parameter int ACQ_TIMEOUT  = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     sample_en,
    input  logic signed [DATA_W-1:0] f_n,
    input  logic                     dfcw_sat,
    output logic [4:0]               kp_shift,
    output logic [4:0]               ki_shift,
    output logic                     pi_clear,
    output logic                     pi_freeze,
    output logic [2:0]               state,
    output logic                     locked,
    output logic                     lol_pulse,
    output logic                     timeout_pulse,
    output logic [7:0]               retry_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_ACQ    = 3'd2,
        ST_TRACK  = 3'd3,
        ST_LOCKED = 3'd4
    } state_t;

    localparam logic [DATA_W:0] ERR_THR_V   = ERR_THR[DATA_W:0];
    localparam logic [15:0]     WIN_LAST    = 16'(WIN_LEN - 1);
    localparam logic [15:0]     CLR_LAST    = 16'(CLR_CYCLES - 1);
    localparam logic [15:0]     GOOD_MIN_V  = 16'(GOOD_MIN);
    localparam logic [15:0]     ACQ_WIN_V   = 16'(ACQ_WINDOWS);
    localparam logic [15:0]     LOCK_WIN_V  = 16'(LOCK_WINDOWS);
    localparam logic [15:0]     FAIL_WIN_V  = 16'(FAIL_WINDOWS);
    localparam logic [15:0]     ACQ_TMO_V   = 16'(ACQ_TIMEOUT);
    localparam logic [4:0]      KP_ACQ_V    = KP_ACQ[4:0];
    localparam logic [4:0]      KI_ACQ_V    = KI_ACQ[4:0];
    localparam logic [4:0]      KP_TRK_V    = KP_TRK[4:0];
    localparam logic [4:0]      KI_TRK_V    = KI_TRK[4:0];

    // Magnitude is one bit wider than the input so that the most negative
    // code maps to its true positive value instead of wrapping.
    function automatic logic [DATA_W:0] abs_ext(input logic signed [DATA_W-1:0] x);
        logic signed [DATA_W:0] xe;
        xe = {x[DATA_W-1], x};
        return (xe < 0) ? unsigned'(-xe) : unsigned'(xe);
    endfunction

    function automatic logic [15:0] inc_sat16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [7:0] inc_sat8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t              cur_state, nxt;
    logic [15:0]         sym_cnt, good_cnt, pass_run, fail_run, acq_win, clr_cnt;
    logic [DATA_W:0]     mag;
    logic                sym_good, counting, strobe, win_done, win_pass;
    logic [15:0]         good_total, pass_run_nx, fail_run_nx, acq_win_nx;
    logic [4:0]          kp_nx, ki_nx;
    logic                clear_nx, freeze_nx, locked_nx, lol_nx, tmo_nx;

    // Per-strobe symbol qualification and end-of-window evaluation.
    always_comb begin
        mag         = abs_ext(f_n);
        sym_good    = (mag <= ERR_THR_V) && !dfcw_sat;
        counting    = (cur_state == ST_ACQ) || (cur_state == ST_TRACK) ||
                      (cur_state == ST_LOCKED);
        strobe      = sample_en && counting;
        win_done    = strobe && (sym_cnt == WIN_LAST);
        good_total  = good_cnt + {15'd0, sym_good};
        win_pass    = (good_total >= GOOD_MIN_V);
        pass_run_nx = win_pass ? inc_sat16(pass_run) : 16'd0;
        fail_run_nx = win_pass ? 16'd0 : inc_sat16(fail_run);
        acq_win_nx  = inc_sat16(acq_win);
    end

    // Next-state selection and the registered outputs of the state being entered.
    always_comb begin
        nxt    = cur_state;
        lol_nx = 1'b0;
        tmo_nx = 1'b0;
        if (!enable) begin
            nxt = ST_IDLE;
        end else begin
            case (cur_state)
                ST_IDLE:   nxt = ST_CLEAR;
                ST_CLEAR:  if (clr_cnt == CLR_LAST) nxt = ST_ACQ;
                ST_ACQ: begin
                    if (win_done) begin
                        // A passing window wins over a timeout on the same edge.
                        if (pass_run_nx == ACQ_WIN_V) begin
                            nxt = ST_TRACK;
                        end else if (acq_win_nx == ACQ_TMO_V) begin
                            nxt    = ST_CLEAR;
                            tmo_nx = 1'b1;
                        end
                    end
                end
                ST_TRACK: begin
                    if (win_done) begin
                        if (pass_run_nx == LOCK_WIN_V)      nxt = ST_LOCKED;
                        else if (fail_run_nx == FAIL_WIN_V) nxt = ST_ACQ;
                    end
                end
                ST_LOCKED: begin
                    if (win_done && (fail_run_nx == FAIL_WIN_V)) begin
                        nxt    = ST_ACQ;
                        lol_nx = 1'b1;
                    end
                end
                default:   nxt = ST_IDLE;
            endcase
        end

        kp_nx     = KP_TRK_V;
        ki_nx     = KI_TRK_V;
        clear_nx  = 1'b0;
        freeze_nx = 1'b0;
        locked_nx = 1'b0;
        case (nxt)
            ST_IDLE: begin
                clear_nx  = 1'b1;
                freeze_nx = 1'b1;
            end
            ST_CLEAR: begin
                clear_nx  = 1'b1;
                freeze_nx = 1'b1;
                kp_nx     = KP_ACQ_V;
                ki_nx     = KI_ACQ_V;
            end
            ST_ACQ: begin
                kp_nx = KP_ACQ_V;
                ki_nx = KI_ACQ_V;
            end
            ST_LOCKED: locked_nx = 1'b1;
            default: ;
        endcase
    end

    // State and output registers; outputs follow the state entered on this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state     <= ST_IDLE;
            kp_shift      <= KP_TRK_V;
            ki_shift      <= KI_TRK_V;
            pi_clear      <= 1'b1;
            pi_freeze     <= 1'b1;
            locked        <= 1'b0;
            lol_pulse     <= 1'b0;
            timeout_pulse <= 1'b0;
            retry_cnt     <= 8'd0;
        end else begin
            cur_state     <= nxt;
            kp_shift      <= kp_nx;
            ki_shift      <= ki_nx;
            pi_clear      <= clear_nx;
            pi_freeze     <= freeze_nx;
            locked        <= locked_nx;
            lol_pulse     <= lol_nx;
            timeout_pulse <= tmo_nx;
            if (tmo_nx) retry_cnt <= inc_sat8(retry_cnt);
        end
    end

    // Window, run and dwell counters; any state change or disable restarts them,
    // which also drops a strobe that lands on a transition edge.
    always_ff @(posedge clk) begin
        if (rst || !enable || (nxt != cur_state)) begin
            sym_cnt  <= 16'd0;
            good_cnt <= 16'd0;
            pass_run <= 16'd0;
            fail_run <= 16'd0;
            acq_win  <= 16'd0;
            clr_cnt  <= 16'd0;
        end else begin
            if (cur_state == ST_CLEAR) clr_cnt <= inc_sat16(clr_cnt);
            if (win_done) begin
                sym_cnt  <= 16'd0;
                good_cnt <= 16'd0;
                pass_run <= pass_run_nx;
                fail_run <= fail_run_nx;
                if (cur_state == ST_ACQ) acq_win <= acq_win_nx;
            end else if (strobe) begin
                sym_cnt  <= sym_cnt + 16'd1;
                good_cnt <= good_total;
            end
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_cdr_lock_sequencer.sv
// Testbench for cdr_lock_sequencer: the stimulus process queues the expected
// output set of every state entry; a monitor pops and compares on each
// observed state change and watches the pulses between changes.
module tb_cdr_lock_sequencer;

    logic               clk = 1'b0;
    logic               rst, enable, sample_en, dfcw_sat;
    logic signed [15:0] f_n;
    logic [4:0]         kp_shift, ki_shift;
    logic               pi_clear, pi_freeze, locked, lol_pulse, timeout_pulse;
    logic [2:0]         state;
    logic [7:0]         retry_cnt;
    logic               mon_en = 1'b0;

    int cyc   = 0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int st, kp, ki, clr, frz, lck, lol, tmo, retry;
        int exp_strobes, exp_cycles, exp_abs;
    } exp_t;

    exp_t sb_q[$];

    cdr_lock_sequencer #(
        .WIN_LEN(16), .GOOD_MIN(14), .ERR_THR(64), .CLR_CYCLES(4),
        .ACQ_WINDOWS(2), .LOCK_WINDOWS(4), .FAIL_WINDOWS(2), .ACQ_TIMEOUT(8)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .sample_en(sample_en),
        .f_n(f_n), .dfcw_sat(dfcw_sat), .kp_shift(kp_shift), .ki_shift(ki_shift),
        .pi_clear(pi_clear), .pi_freeze(pi_freeze), .state(state), .locked(locked),
        .lol_pulse(lol_pulse), .timeout_pulse(timeout_pulse), .retry_cnt(retry_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input int id, input string what, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL entry %0d %s: got %0d, expected %0d", id, what, act, exp);
        end
    endtask

    task automatic push_exp(input int st, input int kp, input int ki, input int clr,
                            input int frz, input int lck, input int lol, input int tmo,
                            input int retry, input int es, input int ec, input int ea);
        exp_t e;
        e.st = st; e.kp = kp; e.ki = ki; e.clr = clr; e.frz = frz; e.lck = lck;
        e.lol = lol; e.tmo = tmo; e.retry = retry;
        e.exp_strobes = es; e.exp_cycles = ec; e.exp_abs = ea;
        sb_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe(input int f, input int sat);
        sample_en = 1'b1;
        f_n       = f[15:0];
        dfcw_sat  = sat[0];
        tick(1);
        sample_en = 1'b0;
        dfcw_sat  = 1'b0;
        tick(1);
    endtask

    // Monitor: compare outputs on every state change, check pulses otherwise.
    initial begin
        int   prev_st;
        int   strobes;
        int   cycles;
        int   ent;
        exp_t e;
        prev_st = 7;
        strobes = 0;
        cycles  = 0;
        ent     = 0;
        wait (mon_en);
        forever begin
            @(negedge clk);
            if (int'(state) != prev_st) begin
                if (sb_q.size() == 0) begin
                    chk(ent, "unexpected_state_change", int'(state), prev_st);
                end else begin
                    e = sb_q.pop_front();
                    chk(ent, "state", int'(state), e.st);
                    chk(ent, "kp_shift", int'(kp_shift), e.kp);
                    chk(ent, "ki_shift", int'(ki_shift), e.ki);
                    chk(ent, "pi_clear", int'(pi_clear), e.clr);
                    chk(ent, "pi_freeze", int'(pi_freeze), e.frz);
                    chk(ent, "locked", int'(locked), e.lck);
                    chk(ent, "lol_pulse", int'(lol_pulse), e.lol);
                    chk(ent, "timeout_pulse", int'(timeout_pulse), e.tmo);
                    chk(ent, "retry_cnt", int'(retry_cnt), e.retry);
                    if (e.exp_strobes >= 0) chk(ent, "strobes_in_prev_state", strobes, e.exp_strobes);
                    if (e.exp_cycles >= 0)  chk(ent, "cycles_in_prev_state", cycles, e.exp_cycles);
                    if (e.exp_abs >= 0)     chk(ent, "change_cycle", cyc, e.exp_abs);
                end
                ent++;
                prev_st = int'(state);
                strobes = 0;
                cycles  = 0;
            end else begin
                chk(ent, "stray_lol_pulse", int'(lol_pulse), 0);
                chk(ent, "stray_timeout_pulse", int'(timeout_pulse), 0);
            end
            cycles++;
            if (sample_en && (state == 3'd2 || state == 3'd3 || state == 3'd4)) strobes++;
        end
    end

    // Stimulus with hand-computed expected entries.
    initial begin
        rst = 1'b1; enable = 1'b0; sample_en = 1'b0; f_n = '0; dfcw_sat = 1'b0;
        // Reset values
        push_exp(0, 12, 18, 1, 1, 0, 0, 0, 0, -1, -1, -1);
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);

        // Enable: CLEAR on the next edge for exactly 4 cycles, then ACQ
        enable = 1'b1;
        push_exp(1, 8, 14, 1, 1, 0, 0, 0, 0, -1, -1, cyc + 1);
        push_exp(2, 8, 14, 0, 0, 0, 0, 0, 0, -1, 4, -1);
        tick(7);

        // Clean signal: TRACK after 2 windows, LOCKED after 4 more
        push_exp(3, 12, 18, 0, 0, 0, 0, 0, 0, 32, -1, -1);
        push_exp(4, 12, 18, 0, 0, 1, 0, 0, 0, 64, -1, -1);
        repeat (96) strobe(10, 0);

        // Large errors in LOCKED: loss of lock after 2 failing windows
        push_exp(2, 8, 14, 0, 0, 0, 1, 0, 0, 32, -1, -1);
        repeat (32) strobe(500, 0);

        // Magnitude / saturation edge cases: first window fails, next two pass
        push_exp(3, 12, 18, 0, 0, 0, 0, 0, 0, 48, -1, -1);
        strobe(-32768, 0);
        strobe(0, 1);
        strobe(65, 0);
        repeat (13) strobe(64, 0);
        strobe(65, 0);
        strobe(-32768, 0);
        strobe(-64, 0);
        repeat (13) strobe(64, 0);
        repeat (16) strobe(10, 0);

        // TRACK falls back to ACQ without a loss-of-lock pulse
        push_exp(2, 8, 14, 0, 0, 0, 0, 0, 0, 32, -1, -1);
        repeat (32) strobe(500, 0);

        // 13 good per window for 8 windows: timeout, retry, CLEAR, ACQ again
        push_exp(1, 8, 14, 1, 1, 0, 0, 1, 1, 128, -1, -1);
        push_exp(2, 8, 14, 0, 0, 0, 0, 0, 1, -1, 4, -1);
        repeat (8) begin
            repeat (3) strobe(500, 0);
            repeat (13) strobe(10, 0);
        end
        tick(6);

        // 14 good per window just passes
        push_exp(3, 12, 18, 0, 0, 0, 0, 0, 1, 32, -1, -1);
        repeat (2) begin
            repeat (2) strobe(500, 0);
            repeat (14) strobe(10, 0);
        end
        push_exp(4, 12, 18, 0, 0, 1, 0, 0, 1, 64, -1, -1);
        repeat (64) strobe(10, 0);
        repeat (3) strobe(10, 0);

        // Disable in LOCKED: IDLE on the next edge, retry count kept
        enable = 1'b0;
        push_exp(0, 12, 18, 1, 1, 0, 0, 0, 1, -1, -1, cyc + 1);
        tick(3);

        // Re-acquire to TRACK, then reset mid-window
        enable = 1'b1;
        push_exp(1, 8, 14, 1, 1, 0, 0, 0, 1, -1, -1, cyc + 1);
        push_exp(2, 8, 14, 0, 0, 0, 0, 0, 1, -1, 4, -1);
        tick(7);
        push_exp(3, 12, 18, 0, 0, 0, 0, 0, 1, 32, -1, -1);
        repeat (32) strobe(10, 0);
        repeat (5) strobe(10, 0);
        rst = 1'b1;
        enable = 1'b0;
        push_exp(0, 12, 18, 1, 1, 0, 0, 0, 0, -1, -1, cyc + 1);
        tick(3);
        rst = 1'b0;
        tick(3);

        for (int i = 0; i < 50 && sb_q.size() != 0; i++) tick(1);
        chk(-1, "pending_expected_entries", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Watchdog against a stalled run.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit, got %0d entries pending, expected 0", sb_q.size());
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cdr_lock_sequencer.md
Name: cdr_lock_sequencer

Overview:
Acquisition and lock controller for the baud-rate Mueller-Muller CDR loop. It sequences the loop through clear, fast acquisition, slow tracking and locked operation by driving the PI loop-filter gain shifts and the clear/freeze controls. It qualifies lock from the phase-detector output f_n, evaluated once per symbol strobe, over fixed windows, and reports lock, loss-of-lock and acquisition timeout.

Parameters:
WIN_LEN, 256, symbols per evaluation window (>=2)
GOOD_MIN, 240, min "good" symbols in a window for the window to pass
ERR_THR, 64, a symbol is good when |f_n| <= ERR_THR and dfcw_sat=0
CLR_CYCLES, 8, clk cycles spent in CLEAR
KP_ACQ, 8, proportional shift in ACQ
KI_ACQ, 14, integral shift in ACQ
KP_TRK, 12, proportional shift in TRACK/LOCKED
KI_TRK, 18, integral shift in TRACK/LOCKED
ACQ_WINDOWS, 4, consecutive passing windows to leave ACQ
LOCK_WINDOWS, 8, consecutive passing windows to leave TRACK
FAIL_WINDOWS, 2, consecutive failing windows that declare loss of lock
ACQ_TIMEOUT, 64, windows allowed in ACQ before retry

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
enable  in  1  run the sequencer; 0 forces IDLE
sample_en  in  1  1-cycle symbol strobe from the DCO
f_n  in  16  signed MMPD error, valid when sample_en=1
dfcw_sat  in  1  frequency-trim clamp active (anti-windup indicator)
kp_shift  out  5  PI proportional shift
ki_shift  out  5  PI integral shift
pi_clear  out  1  zero the PI accumulator and v_ctrl
pi_freeze  out  1  hold the integrator
state  out  3  IDLE=0, CLEAR=1, ACQ=2, TRACK=3, LOCKED=4
locked  out  1  high only in LOCKED
lol_pulse  out  1  1-cycle pulse on LOCKED->ACQ
timeout_pulse  out  1  1-cycle pulse on ACQ timeout
retry_cnt  out  8  saturating count of ACQ timeouts; cleared by rst only

Behaviour:
- All outputs are registered. Reset values: state=IDLE, kp_shift=KP_TRK, ki_shift=KI_TRK, pi_clear=1, pi_freeze=1, locked=0, both pulses=0, retry_cnt=0, all counters=0.
- Per-state outputs:
  - IDLE: clear=1, freeze=1, TRK gains.
  - CLEAR: clear=1, freeze=1, ACQ gains.
  - ACQ: clear=0, freeze=0, ACQ gains.
  - TRACK/LOCKED: clear=0, freeze=0, TRK gains.
- Output values change on the same edge that enters the state.
- Good-symbol test: mag = |f_n|, computed in 17 bits; -32768 gives 32768. A symbol is good when mag <= ERR_THR and dfcw_sat=0 at the strobe.
- Counters:
  - sym_cnt counts strobes.
  - good_cnt counts good strobes.
  - On the strobe that makes sym_cnt reach WIN_LEN, that symbol is included and the window is evaluated. The window passes when good_cnt (including this symbol) >= GOOD_MIN.
  - After evaluation, sym_cnt and good_cnt reset to 0 on that same edge.
  - pass_run and fail_run count consecutive passing/failing windows; each clears the other on a window result.
  - acq_win counts windows spent in ACQ.
- Transitions (taken on the evaluating edge):
  - IDLE->CLEAR when enable=1.
  - CLEAR->ACQ after exactly CLR_CYCLES cycles in CLEAR.
  - ACQ->TRACK when pass_run reaches ACQ_WINDOWS.
  - ACQ->CLEAR when acq_win reaches ACQ_TIMEOUT without a transition: pulse timeout_pulse, increment retry_cnt (saturates at 255). Pass has priority over timeout on the same window.
  - TRACK->LOCKED when pass_run reaches LOCK_WINDOWS.
  - TRACK->ACQ when fail_run reaches FAIL_WINDOWS; no lol_pulse.
  - LOCKED->ACQ when fail_run reaches FAIL_WINDOWS; pulse lol_pulse.
- Every state change clears sym_cnt, good_cnt, pass_run, fail_run and acq_win. A strobe arriving on the transition cycle is discarded, not counted.
- enable=0 in any state forces IDLE on the next edge and clears all counters except retry_cnt. enable has priority over all transitions.
- rst mid-operation returns every output to its reset value on the next edge.
- Strobes in IDLE and CLEAR are ignored.

Test Plan:
Overrides for all tests: WIN_LEN=16, GOOD_MIN=14, ERR_THR=64, CLR_CYCLES=4, ACQ_WINDOWS=2, LOCK_WINDOWS=4, FAIL_WINDOWS=2, ACQ_TIMEOUT=8. Strobe every 2 clk.
1. Reset then enable=1 -> CLEAR for 4 cycles with pi_clear=1 and kp/ki=8/14, then ACQ with pi_clear=0.
2. f_n=10 on every strobe -> TRACK after 32 strobes with kp/ki=12/18, LOCKED after a further 64 strobes, locked=1.
3. In LOCKED, f_n=500 for 32 strobes -> exactly one lol_pulse, state=ACQ, gains 8/14.
4. In ACQ, 3 bad strobes per window (13 good < 14) for 8 windows -> timeout_pulse, retry_cnt=1, CLEAR, then ACQ again. Same with 2 bad per window (14 good) -> passes to TRACK.
5. f_n=-32768 with dfcw_sat=0, and f_n=0 with dfcw_sat=1 -> both counted bad. f_n=64 -> counted good, f_n=65 -> counted bad.
6. enable=0 in LOCKED -> IDLE on the next edge, locked=0, pi_clear=1, retry_cnt held. rst asserted in TRACK -> all outputs at reset values.
